// File: rtl/shift_deser.sv
// Serial-in/parallel-out receiver: collects WIDTH bits (MSB- or LSB-first per word)
// and presents each completed word on a valid/ready output register.
module shift_deser #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovalid_q, ovalid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    ovalid_d  = ovalid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;
    shifted   = dir_q ? {bit_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], bit_in};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          dir_d   = dir;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          sr_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed word either lands in the output register or, if the
    // consumer is still holding the previous one, is dropped and flagged.
    if (complete) begin
      if (!ovalid_q || out_ready) begin
        word_d   = shifted;
        ovalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_out  = word_q;
  assign out_valid = ovalid_q;
  assign busy      = (state_q == COLLECT);
  assign bit_cnt   = cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: bit order, gaps, overrun, back-pressure and reset.
module tb_shift_deser;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst, start, dir, bit_in, bit_valid, out_ready;
  logic [WIDTH-1:0] word_out;
  logic             out_valid, busy, overrun;
  logic [CNT_W-1:0] bit_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  shift_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready), .word_out(word_out),
    .out_valid(out_valid), .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_word(input logic d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
  endtask

  // Sends all WIDTH bits back-to-back; out_ready is raised with the last bit if rdy_last.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic d, input logic rdy_last);
    start_word(d);
    for (int i = 0; i < WIDTH; i++) begin
      bit_in    = d ? w[i] : w[WIDTH-1-i];
      bit_valid = 1'b1;
      if (i == WIDTH - 1 && rdy_last) out_ready = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst = 1'b0; start = 1'b0; dir = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_word", word_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_ovr", overrun, 0);

    // Bits while idle are ignored
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    chk("idle_cnt", bit_cnt, 0);
    chk("idle_busy", busy, 0);

    // 1: MSB-first
    out_ready = 1'b1;
    w = 16'hB76B;
    start_word(1'b0);
    chk("t1_busy_start", busy, 1);
    for (int i = 0; i < WIDTH; i++) begin
      bit_in = w[WIDTH-1-i]; bit_valid = 1'b1;
      tick();
      if (i == WIDTH - 2) begin
        chk("t1_cnt15", bit_cnt, 15);
        chk("t1_valid_early", out_valid, 0);
      end
    end
    bit_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_word", word_out, 16'hB76B);
    chk("t1_busy", busy, 0);
    chk("t1_cnt0", bit_cnt, 0);
    tick();
    chk("t1_consumed", out_valid, 0);
    chk("t1_hold", word_out, 16'hB76B);

    // 2: LSB-first
    send_word(16'hB76B, 1'b1, 1'b1);
    chk("t2_valid", out_valid, 1);
    chk("t2_word", word_out, 16'hB76B);
    tick();
    chk("t2_consumed", out_valid, 0);

    // 3: gaps after bits 4 and 11 of 16'h00FF
    w = 16'h00FF;
    start_word(1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      bit_in = w[WIDTH-1-i]; bit_valid = 1'b1;
      tick();
      if (i == 3 || i == 10) begin
        bit_valid = 1'b0; bit_in = ~bit_in;
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("t3_gap_cnt", bit_cnt, i + 1);
        end
      end
    end
    bit_valid = 1'b0;
    chk("t3_valid", out_valid, 1);
    chk("t3_word", word_out, 16'h00FF);
    tick();

    // 4: overrun with out_ready held low
    out_ready = 1'b0;
    send_word(16'h1234, 1'b0, 1'b0);
    chk("t4_word1", word_out, 16'h1234);
    chk("t4_valid1", out_valid, 1);
    chk("t4_ovr0", overrun, 0);
    send_word(16'hABCD, 1'b0, 1'b0);
    chk("t4_word_kept", word_out, 16'h1234);
    chk("t4_valid_kept", out_valid, 1);
    chk("t4_ovr1", overrun, 1);
    out_ready = 1'b1;
    tick();
    chk("t4_consumed", out_valid, 0);
    chk("t4_ovr_sticky", overrun, 1);
    chk("t4_word_hold", word_out, 16'h1234);

    // 5: release back-pressure in the completion cycle
    do_reset();
    chk("t5_ovr_clr", overrun, 0);
    out_ready = 1'b0;
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'hABCD, 1'b0, 1'b1);
    chk("t5_word", word_out, 16'hABCD);
    chk("t5_valid", out_valid, 1);
    chk("t5_ovr", overrun, 0);
    tick();
    chk("t5_consumed", out_valid, 0);

    // 6: reset after 7 bits, then a fresh word with stray starts
    start_word(1'b1);
    for (int i = 0; i < 7; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("t6_cnt7", bit_cnt, 7);
    do_reset();
    chk("t6_word", word_out, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnt", bit_cnt, 0);
    chk("t6_ovr", overrun, 0);
    w = 16'h5A5A;
    start_word(1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      bit_in = w[WIDTH-1-i]; bit_valid = 1'b1;
      start = (i == 5 || i == WIDTH - 1);
      dir   = 1'b1;
      tick();
      if (i == 5) chk("t6_restart_ignored", bit_cnt, 6);
    end
    bit_valid = 1'b0;
    chk("t6_fresh_word", word_out, 16'h5A5A);
    chk("t6_fresh_valid", out_valid, 1);
    chk("t6_start_at_done", busy, 0);
    tick();
    start = 1'b0;
    chk("t6_start_next", busy, 1);
    chk("t6_start_cnt", bit_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
